// File: rtl/wb_port_arbiter.sv
// Shares one scoreboard write-back port between NR_REQ functional units.
// Each unit owns a one-deep holding slot; full slots are served round-robin.
module wb_port_arbiter #(
  parameter int NR_REQ        = 3,
  parameter int TRANS_ID_BITS = 3,
  parameter int DATA_W        = 64
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   flush_i,
  input  logic [NR_REQ-1:0]                      req_valid_i,
  output logic [NR_REQ-1:0]                      req_ready_o,
  input  logic [NR_REQ-1:0][TRANS_ID_BITS-1:0]   req_trans_id_i,
  input  logic [NR_REQ-1:0][DATA_W-1:0]          req_data_i,
  input  logic [NR_REQ-1:0]                      req_ex_valid_i,
  output logic                                   wt_valid_o,
  output logic [TRANS_ID_BITS-1:0]               trans_id_o,
  output logic [DATA_W-1:0]                      wbdata_o,
  output logic                                   ex_valid_o,
  output logic [NR_REQ-1:0]                      grant_o
);

  localparam int RR_W = $clog2(NR_REQ);

  logic [NR_REQ-1:0]                    full_q, full_d;
  logic [NR_REQ-1:0][TRANS_ID_BITS-1:0] id_q;
  logic [NR_REQ-1:0][DATA_W-1:0]        data_q;
  logic [NR_REQ-1:0]                    ex_q;
  logic [RR_W-1:0]                      rr_q, rr_d;

  logic [RR_W-1:0]   grant_idx;
  logic [RR_W-1:0]   cand;
  logic              found;
  logic              grant_valid;
  logic [NR_REQ-1:0] capture;

  // Round-robin search over held results only; this cycle's inputs are never eligible.
  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NR_REQ; k++) begin
      cand = RR_W'((int'(rr_q) + k) % NR_REQ);
      if (!found && full_q[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign grant_valid = found & ~flush_i;
  assign grant_o     = grant_valid ? (NR_REQ'(1) << grant_idx) : '0;
  assign wt_valid_o  = grant_valid;
  assign trans_id_o  = grant_valid ? id_q[grant_idx]   : '0;
  assign wbdata_o    = grant_valid ? data_q[grant_idx] : '0;
  assign ex_valid_o  = grant_valid ? ex_q[grant_idx]   : 1'b0;

  // A slot being drained this cycle may be refilled in the same cycle.
  assign req_ready_o = (~full_q | grant_o) & {NR_REQ{~flush_i & ~rst_i}};

  always_comb begin
    full_d  = full_q;
    rr_d    = rr_q;
    capture = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      capture[i] = req_valid_i[i] & req_ready_o[i];
      if (flush_i)         full_d[i] = 1'b0;
      else if (capture[i]) full_d[i] = 1'b1;
      else if (grant_o[i]) full_d[i] = 1'b0;
    end
    if (grant_valid) rr_d = grant_idx;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: slot payload is reset too, so trans_id/data read back as zero after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= '0;
      id_q   <= '0;
      data_q <= '0;
      ex_q   <= '0;
      rr_q   <= RR_W'(NR_REQ - 1);
    end else begin
      full_q <= full_d;
      rr_q   <= rr_d;
      for (int i = 0; i < NR_REQ; i++) begin
        if (capture[i]) begin
          id_q[i]   <= req_trans_id_i[i];
          data_q[i] <= req_data_i[i];
          ex_q[i]   <= req_ex_valid_i[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, single, contention, round-robin,
// streaming, flush and asynchronous reset during a transfer.
module tb_wb_port_arbiter;

  localparam int NR = 3;
  localparam int TW = 3;
  localparam int DW = 64;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   flush;
  logic [NR-1:0]          req_valid;
  logic [NR-1:0]          req_ready;
  logic [NR-1:0][TW-1:0]  req_id;
  logic [NR-1:0][DW-1:0]  req_data;
  logic [NR-1:0]          req_ex;
  logic                   wt_valid;
  logic [TW-1:0]          trans_id;
  logic [DW-1:0]          wbdata;
  logic                   ex_valid;
  logic [NR-1:0]          grant;

  int n_tests = 0;
  int n_fail  = 0;

  // Packed view of the write-back port: {valid, grant, id, data, ex}.
  wire [71:0] wb_obs = {wt_valid, grant, trans_id, wbdata, ex_valid};

  always #5 clk = ~clk;

  wb_port_arbiter #(.NR_REQ(NR), .TRANS_ID_BITS(TW), .DATA_W(DW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_trans_id_i (req_id),
    .req_data_i     (req_data),
    .req_ex_valid_i (req_ex),
    .wt_valid_o     (wt_valid),
    .trans_id_o     (trans_id),
    .wbdata_o       (wbdata),
    .ex_valid_o     (ex_valid),
    .grant_o        (grant)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    req_id    = '0;
    req_data  = '0;
    req_ex    = '0;
    flush     = 1'b0;
  endtask

  task automatic push(input int i, input logic [TW-1:0] id, input logic [DW-1:0] d,
                      input logic ex);
    req_valid[i] = 1'b1;
    req_id[i]    = id;
    req_data[i]  = d;
    req_ex[i]    = ex;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    idle_inputs();
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [71:0] exp;
    idle_inputs();
    #3;
    exp = '0;
    n_tests++;
    if (wb_obs !== exp) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", wb_obs, exp); end
    n_tests++;
    if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready: got %b want 000", req_ready); end
    next_cycle();
    rst = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 3'b111) begin n_fail++; $display("FAIL post_reset_ready: got %b want 111", req_ready); end
    n_tests++;
    if (wb_obs !== exp) begin n_fail++; $display("FAIL post_reset_idle: got %h want %h", wb_obs, exp); end
  endtask

  task automatic test_single();
    logic [71:0] exp;
    next_cycle();
    push(1, 3'd5, 64'hDEAD_BEEF, 1'b0);
    #1;
    n_tests++;
    if (wt_valid !== 1'b0) begin n_fail++; $display("FAIL single_c0_same_cycle: got %b want 0", wt_valid); end
    next_cycle();
    idle_inputs();
    #1;
    exp = {1'b1, 3'b010, 3'd5, 64'hDEAD_BEEF, 1'b0};
    n_tests++;
    if (wb_obs !== exp) begin n_fail++; $display("FAIL single_c1: got %h want %h", wb_obs, exp); end
    next_cycle();
    #1;
    exp = '0;
    n_tests++;
    if (wb_obs !== exp) begin n_fail++; $display("FAIL single_c2_idle: got %h want %h", wb_obs, exp); end
  endtask

  task automatic test_contention();
    logic [71:0] exp;
    do_reset();
    next_cycle();
    push(0, 3'd1, 64'h11, 1'b0);
    push(1, 3'd2, 64'h22, 1'b0);
    push(2, 3'd3, 64'h33, 1'b1);
    next_cycle();
    idle_inputs();
    #1;
    exp = {1'b1, 3'b001, 3'd1, 64'h11, 1'b0};
    n_tests++;
    if (wb_obs !== exp) begin n_fail++; $display("FAIL contention_c1: got %h want %h", wb_obs, exp); end
    n_tests++;
    if (req_ready !== 3'b001) begin n_fail++; $display("FAIL contention_c1_ready: got %b want 001", req_ready); end
    next_cycle();
    #1;
    exp = {1'b1, 3'b010, 3'd2, 64'h22, 1'b0};
    n_tests++;
    if (wb_obs !== exp) begin n_fail++; $display("FAIL contention_c2: got %h want %h", wb_obs, exp); end
    n_tests++;
    if (req_ready !== 3'b011) begin n_fail++; $display("FAIL contention_c2_ready: got %b want 011", req_ready); end
    next_cycle();
    #1;
    exp = {1'b1, 3'b100, 3'd3, 64'h33, 1'b1};
    n_tests++;
    if (wb_obs !== exp) begin n_fail++; $display("FAIL contention_c3: got %h want %h", wb_obs, exp); end
    next_cycle();
    #1;
    exp = '0;
    n_tests++;
    if (wb_obs !== exp) begin n_fail++; $display("FAIL contention_c4_idle: got %h want %h", wb_obs, exp); end
  endtask

  task automatic test_rr_wrap();
    logic [71:0] exp;
    logic [NR-1:0] exp_g [4];
    logic [TW-1:0] exp_id [4];
    exp_g  = '{3'b001, 3'b100, 3'b001, 3'b100};
    exp_id = '{3'd4, 3'd6, 3'd4, 3'd6};
    do_reset();
    next_cycle();
    push(0, 3'd4, 64'h40, 1'b0);
    push(2, 3'd6, 64'h60, 1'b0);
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      #1;
      exp = {1'b1, exp_g[c], exp_id[c], (exp_id[c] == 3'd4) ? 64'h40 : 64'h60, 1'b0};
      n_tests++;
      if (wb_obs !== exp) begin n_fail++; $display("FAIL rr_wrap_c%0d: got %h want %h", c + 1, wb_obs, exp); end
      if (c == 1) begin
        n_tests++;
        if (req_ready !== 3'b110) begin n_fail++; $display("FAIL rr_wrap_stall_ready: got %b want 110", req_ready); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [71:0] exp;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      push(0, TW'(k), 64'h100 + 64'(k), 1'b0);
      #1;
      n_tests++;
      if (req_ready[0] !== 1'b1) begin n_fail++; $display("FAIL stream_ready_c%0d: got %b want 1", k, req_ready[0]); end
      if (k > 0) begin
        exp = {1'b1, 3'b001, TW'(k - 1), 64'h100 + 64'(k - 1), 1'b0};
        n_tests++;
        if (wb_obs !== exp) begin n_fail++; $display("FAIL stream_wb_c%0d: got %h want %h", k, wb_obs, exp); end
      end
    end
    next_cycle();
    idle_inputs();
    #1;
    exp = {1'b1, 3'b001, 3'd7, 64'h107, 1'b0};
    n_tests++;
    if (wb_obs !== exp) begin n_fail++; $display("FAIL stream_wb_last: got %h want %h", wb_obs, exp); end
  endtask

  task automatic test_flush();
    logic [71:0] exp;
    do_reset();
    next_cycle();
    push(0, 3'd1, 64'hA1, 1'b0);
    push(2, 3'd3, 64'hA3, 1'b0);
    next_cycle();
    idle_inputs();
    flush = 1'b1;
    #1;
    exp = '0;
    n_tests++;
    if (wb_obs !== exp) begin n_fail++; $display("FAIL flush_cycle: got %h want %h", wb_obs, exp); end
    n_tests++;
    if (req_ready !== 3'b000) begin n_fail++; $display("FAIL flush_ready: got %b want 000", req_ready); end
    next_cycle();
    flush = 1'b0;
    push(0, 3'd6, 64'hB6, 1'b0);
    push(2, 3'd7, 64'hB7, 1'b0);
    #1;
    n_tests++;
    if (wb_obs !== exp) begin n_fail++; $display("FAIL flush_after: got %h want %h", wb_obs, exp); end
    next_cycle();
    idle_inputs();
    #1;
    exp = {1'b1, 3'b001, 3'd6, 64'hB6, 1'b0};
    n_tests++;
    if (wb_obs !== exp) begin n_fail++; $display("FAIL flush_rr_kept: got %h want %h", wb_obs, exp); end
    next_cycle();
    #1;
    exp = {1'b1, 3'b100, 3'd7, 64'hB7, 1'b0};
    n_tests++;
    if (wb_obs !== exp) begin n_fail++; $display("FAIL flush_new_fu2: got %h want %h", wb_obs, exp); end
  endtask

  task automatic test_reset_mid();
    logic [71:0] exp;
    do_reset();
    next_cycle();
    push(1, 3'd2, 64'hC2, 1'b1);
    next_cycle();
    idle_inputs();
    #1;
    exp = {1'b1, 3'b010, 3'd2, 64'hC2, 1'b1};
    n_tests++;
    if (wb_obs !== exp) begin n_fail++; $display("FAIL rst_mid_before: got %h want %h", wb_obs, exp); end
    #1;
    rst = 1'b1;
    #1;
    exp = '0;
    n_tests++;
    if (wb_obs !== exp) begin n_fail++; $display("FAIL rst_mid_immediate: got %h want %h", wb_obs, exp); end
    n_tests++;
    if (req_ready !== 3'b000) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 000", req_ready); end
    #1;
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      #1;
      n_tests++;
      if (wb_obs !== exp) begin n_fail++; $display("FAIL rst_mid_after_c%0d: got %h want %h", c, wb_obs, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_rr_wrap();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
